// File: rtl/set_host.sv
// Host-side controller for the SET candidate-counting engine: queues circle-query jobs,
// issues them one at a time and returns tagged results, with a watchdog for hung engines.
module set_host #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_central,
  input  logic [11:0] cmd_radius,
  input  logic [1:0]  cmd_mode,
  input  logic [3:0]  cmd_tag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_candidate,
  output logic [3:0]  res_tag,
  output logic        res_timeout,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate
);
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam logic [7:0]  WdogMax = 8'(TIMEOUT);

  typedef struct packed {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic [3:0]  tag;
  } job_t;

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StResult} state_e;

  job_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  job_t            head;
  logic            full, empty, push, pop;

  state_e          state_q;
  logic [7:0]      wdog_q;
  logic [3:0]      tag_q;
  logic            wdog_hit;

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign wdog_hit  = (wdog_q == WdogMax);
  // The head leaves the queue once the engine has taken it, or when it is abandoned.
  assign pop       = (state_q == StIssue) && (set_busy || wdog_hit);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{central: cmd_central, radius: cmd_radius, mode: cmd_mode, tag: cmd_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wdog_q        <= '0;
      tag_q         <= '0;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
      res_timeout   <= 1'b0;
    end else begin
      if ((state_q == StIssue || state_q == StRun) && !wdog_hit) begin
        wdog_q <= wdog_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          // A job abandoned in ISSUE may still make the engine go busy; wait it out.
          if (!empty && !set_busy) begin
            set_central <= head.central;
            set_radius  <= head.radius;
            set_mode    <= head.mode;
            tag_q       <= head.tag;
            wdog_q      <= '0;
            set_en      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (set_busy) begin
            set_en  <= 1'b0;
            state_q <= StRun;
          end else if (wdog_hit) begin
            set_en        <= 1'b0;
            res_valid     <= 1'b1;
            res_timeout   <= 1'b1;
            res_candidate <= '0;
            res_tag       <= tag_q;
            state_q       <= StResult;
          end
        end
        StRun: begin
          // RUN is only entered after busy was seen, so a valid here belongs to this job.
          if (!set_busy && set_valid) begin
            res_valid     <= 1'b1;
            res_timeout   <= 1'b0;
            res_candidate <= set_candidate;
            res_tag       <= tag_q;
            state_q       <= StResult;
          end else if (wdog_hit) begin
            res_valid     <= 1'b1;
            res_timeout   <= 1'b1;
            res_candidate <= '0;
            res_tag       <= tag_q;
            state_q       <= StResult;
          end
        end
        StResult: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
